// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: baud constants, status nibbles, top FSM states
// and the message classification helpers used at request acceptance.
package midi_pkg;

  localparam int MIDI_BAUD            = 31250;
  localparam int CLK_FREQ             = 50_000_000;
  localparam int DEFAULT_CLKS_PER_BIT = CLK_FREQ / MIDI_BAUD;

  localparam logic [3:0] NOTE_OFF  = 4'h8;
  localparam logic [3:0] NOTE_ON   = 4'h9;
  localparam logic [3:0] PROG_CHG  = 4'hC;
  localparam logic [3:0] CHAN_PRES = 4'hD;

  localparam int BITS_PER_FRAME = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_e;

  // Program change and channel pressure carry a single data byte.
  function automatic logic is_two_byte(input logic [7:0] status);
    return (status[7:4] == PROG_CHG) || (status[7:4] == CHAN_PRES);
  endfunction

  // Status must have bit7 set; every data byte that is actually sent must not.
  function automatic logic msg_valid(input logic [23:0] msg);
    return msg[23] && !msg[15] && (is_two_byte(msg[23:16]) || !msg[7]);
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// Single-byte 8N1 serialiser. done_o is raised in the final stop-bit cycle so a
// start_i in that same cycle chains the next frame without an idle gap.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(BITS_PER_FRAME - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign frame_end = busy_q && bit_end && (bit_q == LAST_BIT);

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    tx_d    = tx_q;
    if (!busy_q || frame_end) begin
      if (start_i) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        shift_d = {1'b1, byte_i};
        cnt_d   = '0;
        bit_d   = 4'd0;
      end else begin
        busy_d = 1'b0;
        tx_d   = 1'b1;
        cnt_d  = '0;
        bit_d  = 4'd0;
      end
    end else if (bit_end) begin
      // Shift register holds data LSB-first with the stop bit parked above it.
      cnt_d   = '0;
      bit_d   = bit_q + 4'd1;
      tx_d    = shift_q[0];
      shift_d = {1'b1, shift_q[8:1]};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = frame_end;
  assign tx_o   = tx_q;

endmodule

// File: rtl/midi_msg_tx.sv
// MIDI channel-message transmitter: validates a 24-bit message, then feeds its
// 2 or 3 bytes back-to-back into the 8N1 serialiser.
module midi_msg_tx
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [23:0] TxData,
  input  logic        TxStart,
  output logic        TxBusy,
  output logic        TxDone,
  output logic        TxError,
  output logic        Tx
);

  tx_state_e   state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        err_q, err_d;

  logic        uart_start;
  logic [7:0]  uart_byte;
  logic        uart_busy;
  logic        uart_done;
  logic        req_ok;

  assign req_ok = msg_valid(TxData);

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    byte_idx_d = byte_idx_q;
    err_d      = 1'b0;
    uart_start = 1'b0;
    uart_byte  = TxData[23:16];
    unique case (state_q)
      ST_IDLE: begin
        if (TxStart && !uart_busy) begin
          if (req_ok) begin
            uart_start = 1'b1;
            data_d     = TxData[15:0];
            byte_cnt_d = is_two_byte(TxData[23:16]) ? 2'd2 : 2'd3;
            byte_idx_d = 2'd1;
            state_d    = ST_SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        // byte_idx_q counts bytes already handed to the serialiser.
        if (uart_done) begin
          if (byte_idx_q == byte_cnt_q) begin
            state_d = ST_DONE;
          end else begin
            uart_start = 1'b1;
            uart_byte  = (byte_idx_q == 2'd1) ? data_q[15:8] : data_q[7:0];
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      byte_cnt_q <= 2'd0;
      byte_idx_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      byte_idx_q <= byte_idx_d;
      err_q      <= err_d;
    end
  end

  midi_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .start_i(uart_start),
    .byte_i (uart_byte),
    .busy_o (uart_busy),
    .done_o (uart_done),
    .tx_o   (Tx)
  );

  assign TxBusy  = (state_q == ST_SEND);
  assign TxDone  = (state_q == ST_DONE);
  assign TxError = err_q;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Bench for midi_msg_tx: two instances (4 and 1600 clocks per bit) checked every
// cycle against a waveform model, plus literal timing/decode checks per message.
`timescale 1ns/1ps
module tb_midi_msg_tx;

  localparam int C0 = 4;
  localparam int C1 = 1600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic [23:0] data  [2];
  logic        tx    [2];
  logic        busy  [2];
  logic        done  [2];
  logic        err   [2];

  midi_msg_tx #(.CLKS_PER_BIT(C0)) dut0 (
    .Clk(clk), .Rst_n(rst_n[0]), .TxData(data[0]), .TxStart(start[0]),
    .TxBusy(busy[0]), .TxDone(done[0]), .TxError(err[0]), .Tx(tx[0]));

  midi_msg_tx #(.CLKS_PER_BIT(C1)) dut1 (
    .Clk(clk), .Rst_n(rst_n[1]), .TxData(data[1]), .TxStart(start[1]),
    .TxBusy(busy[1]), .TxDone(done[1]), .TxError(err[1]), .Tx(tx[1]));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d) at t=%0t: got %0h, expected %0h", name, u, $time, act, exp);
  endtask

  function automatic int cpb(input int u);
    return (u == 0) ? C0 : C1;
  endfunction

  function automatic bit two_byte(input logic [23:0] d);
    return (d[23:20] == 4'hC) || (d[23:20] == 4'hD);
  endfunction

  function automatic bit msg_ok(input logic [23:0] d);
    return d[23] && !d[15] && (two_byte(d) || !d[7]);
  endfunction

  // Model: pos 0 = idle, 1..len = cycles of line activity since acceptance,
  // len+1 = done cycle. Line value is the frame bit covering that cycle.
  int   pos [2];
  int   len [2];
  logic mbits [2][30];
  logic merr [2];
  bit   model_on = 1'b0;
  int   m_nb;
  logic [7:0] m_byte;

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      merr[u] = 1'b0;
      if (rst_n[u] !== 1'b1) begin
        pos[u] = 0;
      end else if (pos[u] == 0) begin
        if (start[u] === 1'b1) begin
          if (msg_ok(data[u])) begin
            m_nb = two_byte(data[u]) ? 2 : 3;
            len[u] = m_nb * 10 * cpb(u);
            for (int b = 0; b < 3; b++) begin
              m_byte = data[u][23 - 8*b -: 8];
              mbits[u][b*10] = 1'b0;
              for (int j = 0; j < 8; j++) mbits[u][b*10 + 1 + j] = m_byte[j];
              mbits[u][b*10 + 9] = 1'b1;
            end
            pos[u] = 1;
          end else begin
            merr[u] = 1'b1;
          end
        end
      end else if (pos[u] == len[u] + 1) begin
        pos[u] = 0;
      end else begin
        pos[u] = pos[u] + 1;
      end
    end
    model_on = 1'b1;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int u = 0; u < 2; u++) begin
        logic etx, ebusy, edone;
        ebusy = (pos[u] >= 1) && (pos[u] <= len[u]);
        edone = (pos[u] != 0) && (pos[u] == len[u] + 1);
        etx   = ebusy ? mbits[u][(pos[u] - 1) / cpb(u)] : 1'b1;
        check("cyc_tx",    u, 32'(tx[u]),   32'(etx));
        check("cyc_busy",  u, 32'(busy[u]), 32'(ebusy));
        check("cyc_done",  u, 32'(done[u]), 32'(edone));
        check("cyc_error", u, 32'(err[u]),  32'(merr[u]));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Pulse TxStart for one cycle, then watch the line until TxDone (bounded).
  // Cycle k=1 is the first cycle after the accepting edge.
  task automatic capture(input int u, input logic [23:0] d, input int nb, input int maxc,
                         output int first_low, output int busy_n, output int done_at,
                         output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                         output bit frame_ok);
    logic trace[$];
    logic [7:0] by [3];
    int c, idx;
    c = cpb(u);
    @(posedge clk); #1; start[u] = 1'b1; data[u] = d;
    @(posedge clk); #1; start[u] = 1'b0;
    first_low = -1; busy_n = 0; done_at = -1; frame_ok = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      trace.push_back(tx[u]);
      if (busy[u] === 1'b1) busy_n++;
      if (tx[u] === 1'b0 && first_low < 0) first_low = k;
      if (done[u] === 1'b1) begin
        done_at = k;
        break;
      end
    end
    for (int b = 0; b < 3; b++) begin
      by[b] = 'x;
      if (first_low > 0 && b < nb) begin
        for (int j = 0; j < 10; j++) begin
          idx = first_low - 1 + (b*10 + j)*c + c/2;
          if (idx >= trace.size()) frame_ok = 1'b0;
          else if (j == 0 && trace[idx] !== 1'b0) frame_ok = 1'b0;
          else if (j == 9 && trace[idx] !== 1'b1) frame_ok = 1'b0;
          else if (j >= 1 && j <= 8) by[b][j-1] = trace[idx];
        end
      end
    end
    b0 = by[0]; b1 = by[1]; b2 = by[2];
    $display("msg dut%0d %06h: first_low=%0d busy=%0d done_at=%0d bytes=%02h %02h %02h",
             u, d, first_low, busy_n, done_at, b0, b1, b2);
  endtask

  task automatic bad_req(input logic [23:0] d);
    @(posedge clk); #1; start[0] = 1'b1; data[0] = d;
    @(posedge clk); #1; start[0] = 1'b0;
    @(negedge clk);
    check("err_pulse", 0, 32'(err[0]), 32'd1);
    check("err_busy",  0, 32'(busy[0]), 32'd0);
    check("err_tx",    0, 32'(tx[0]),   32'd1);
    @(negedge clk);
    check("err_clear", 0, 32'(err[0]), 32'd0);
    $display("rejected dut0 %06h", d);
  endtask

  initial begin
    int fl, bn, da, dk, ndone;
    logic [7:0] b0, b1, b2;
    bit fok;
    logic [23:0] rd;

    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; start[u] = 1'b0; data[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1; rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    check("rst_tx", 0, 32'(tx[0]), 32'd1);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);
    check("rst_done", 0, 32'(done[0]), 32'd0);
    check("rst_error", 0, 32'(err[0]), 32'd0);
    repeat (100) @(posedge clk);

    // Note on, three bytes.
    capture(0, 24'h903C64, 3, 200, fl, bn, da, b0, b1, b2, fok);
    check("non_first_low", 0, fl, 1);
    check("non_done_at",   0, da, 121);
    check("non_busy_cyc",  0, bn, 120);
    check("non_byte0", 0, b0, 8'h90);
    check("non_byte1", 0, b1, 8'h3C);
    check("non_byte2", 0, b2, 8'h64);
    check("non_frame", 0, 32'(fok), 32'd1);

    // Program change: two bytes, data2 bit7 is irrelevant.
    capture(0, 24'hC005FF, 2, 200, fl, bn, da, b0, b1, b2, fok);
    check("pc_done_at",  0, da, 81);
    check("pc_busy_cyc", 0, bn, 80);
    check("pc_byte0", 0, b0, 8'hC0);
    check("pc_byte1", 0, b1, 8'h05);
    check("pc_frame", 0, 32'(fok), 32'd1);

    bad_req(24'h103C64);
    bad_req(24'h90BC64);
    bad_req(24'h903CE4);

    // Second request during a transmission is dropped.
    @(posedge clk); #1; start[0] = 1'b1; data[0] = 24'h803C00;
    @(posedge clk); #1; start[0] = 1'b0;
    dk = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 50) begin start[0] = 1'b1; data[0] = 24'h913000; end
      else if (k == 51) start[0] = 1'b0;
      if (done[0] === 1'b1) begin dk = k; break; end
    end
    check("ign_done_at", 0, dk, 121);
    $display("msg dut0 803C00 with ignored 913000: done_at=%0d", dk);

    // TxStart held high: next accept happens in the idle cycle after done.
    start[0] = 1'b1; data[0] = 24'h913000;
    @(negedge clk);
    check("hold_gap_tx",   0, 32'(tx[0]), 32'd1);
    check("hold_gap_busy", 0, 32'(busy[0]), 32'd0);
    @(negedge clk);
    check("hold_start_tx",   0, 32'(tx[0]), 32'd0);
    check("hold_start_busy", 0, 32'(busy[0]), 32'd1);
    start[0] = 1'b0;
    dk = -1;
    for (int k = 2; k <= 200; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin dk = k; break; end
    end
    check("hold_done_at", 0, dk, 121);
    $display("msg dut0 913000 (held start): done_at=%0d", dk);

    // Reset in the middle of a message.
    @(posedge clk); #1; start[0] = 1'b1; data[0] = 24'h903C64;
    @(posedge clk); #1; start[0] = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done[0] === 1'b1) ndone++;
      if (k == 37) rst_n[0] = 1'b0;
      if (k == 38) begin
        rst_n[0] = 1'b1;
        check("abort_tx",   0, 32'(tx[0]), 32'd1);
        check("abort_busy", 0, 32'(busy[0]), 32'd0);
      end
    end
    check("abort_no_done", 0, ndone, 0);
    $display("msg dut0 903C64 aborted by reset at cycle 37");
    capture(0, 24'h803C00, 3, 200, fl, bn, da, b0, b1, b2, fok);
    check("post_done_at", 0, da, 121);
    check("post_byte0", 0, b0, 8'h80);
    check("post_byte1", 0, b1, 8'h3C);
    check("post_byte2", 0, b2, 8'h00);
    check("post_frame", 0, 32'(fok), 32'd1);

    // Randomised traffic: valid/invalid messages, data churn, stray starts, resets.
    for (int i = 0; i < 30; i++) begin
      int hold, gap;
      rd = {($urandom_range(0, 6) == 0) ? 1'b0 : 1'b1, 7'($urandom),
            ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, 7'($urandom), 8'($urandom)};
      @(negedge clk);
      start[0] = 1'b1; data[0] = rd;
      $display("rand %0d dut0 request %06h valid=%0d", i, rd, msg_ok(rd));
      hold = $urandom_range(1, 3);
      repeat (hold) @(negedge clk);
      start[0] = 1'b0;
      gap = $urandom_range(0, 350);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        data[0] = 24'($urandom);
        start[0] = ($urandom_range(0, 60) == 0);
        rst_n[0] = ($urandom_range(0, 400) == 0) ? 1'b0 : 1'b1;
      end
    end
    @(negedge clk);
    start[0] = 1'b0; rst_n[0] = 1'b1;
    repeat (400) @(negedge clk);

    // Full-rate baud divisor.
    capture(1, 24'h903C64, 3, 48100, fl, bn, da, b0, b1, b2, fok);
    check("slow_first_low", 1, fl, 1);
    check("slow_done_at",   1, da, 48001);
    check("slow_busy_cyc",  1, bn, 48000);
    check("slow_byte0", 1, b0, 8'h90);
    check("slow_byte1", 1, b1, 8'h3C);
    check("slow_byte2", 1, b2, 8'h64);
    check("slow_frame", 1, 32'(fok), 32'd1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
